// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto one memory port; data has priority with a starvation cap for fetch.
// Zero-wait latency: grant in IDLE, mem_req next cycle, ready pulse one cycle after mem_ack; stall holds requesters.
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              stall
);

  typedef enum logic [1:0] {IDLE, SERVE_IF, SERVE_DM, DONE} state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t            state, stateNext;
  logic              ifEff, starveHit, grantDm, grantIf;
  logic              winIf, kill, weQ;
  logic [3:0]        starveCnt;
  logic [ADDR_W-1:0] addrQ;
  logic [DATA_W-1:0] wdataQ;

  // A flush in IDLE withdraws the fetch from arbitration for that cycle.
  assign ifEff     = if_req & ~if_flush;
  assign starveHit = ifEff & (starveCnt == STARVE_LIM);
  assign grantDm   = dm_req & ~starveHit;
  assign grantIf   = ifEff & ~grantDm;

  assign mem_addr  = addrQ;
  assign mem_wdata = wdataQ;
  assign mem_we    = weQ & (state == SERVE_DM);
  assign stall     = (if_req & ~if_ready & ~if_flush) | (dm_req & ~dm_ready);

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    mem_req   = 1'b0;
    if_ready  = 1'b0;
    dm_ready  = 1'b0;
    case (state)
      IDLE: begin
        if (grantDm)      stateNext = SERVE_DM;
        else if (grantIf) stateNext = SERVE_IF;
      end
      SERVE_IF, SERVE_DM: begin
        mem_req = 1'b1;
        if (mem_ack) stateNext = DONE;
      end
      DONE: begin
        if_ready  = winIf & ~kill;
        dm_ready  = ~winIf;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      starveCnt <= '0;
      kill      <= 1'b0;
      winIf     <= 1'b0;
      weQ       <= 1'b0;
      addrQ     <= '0;
      wdataQ    <= '0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
    end else begin
      if (state == IDLE && (grantDm || grantIf)) begin
        winIf  <= ~grantDm;
        addrQ  <= grantDm ? dm_addr : if_addr;
        weQ    <= grantDm & dm_we;
        wdataQ <= grantDm ? dm_wdata : '0;
        if (grantDm && ifEff)
          starveCnt <= (starveCnt < STARVE_LIM) ? starveCnt + 4'd1 : starveCnt;
        else
          starveCnt <= '0;
      end
      if (state == SERVE_IF && if_flush) kill <= 1'b1;
      // DONE always leads to IDLE, so this is the IDLE-entry clear.
      if (state == DONE) kill <= 1'b0;
      if (state == SERVE_IF && mem_ack && !kill && !if_flush) if_rdata <= mem_rdata;
      if (state == SERVE_DM && mem_ack && !weQ) dm_rdata <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch, collision, starvation, wait-state store, flush, mid-transaction reset.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0, if_flush = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        dm_req = 1'b0, dm_we = 1'b0;
  logic [31:0] dm_addr = '0, dm_wdata = '0;
  logic [31:0] dm_rdata;
  logic        dm_ready;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        stall;

  int ackDelay = 0;
  int waitCnt  = 0;
  int checks   = 0;
  int failures = 0;

  logic [31:0] grantAddr;
  logic        gotIf;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(3)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_rdata(if_rdata), .if_ready(if_ready),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ready(dm_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .stall(stall)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memData(input logic [31:0] a);
    case (a)
      32'h40:  return 32'h8C080004;
      32'h100: return 32'h0000CAFE;
      default: return a ^ 32'h5A5A0000;
    endcase
  endfunction

  // Memory model: acks after ackDelay wait cycles, combinationally so zero-wait acks land with mem_req.
  assign mem_rdata = memData(mem_addr);
  assign mem_ack   = mem_req && (waitCnt >= ackDelay);
  always @(posedge clk) waitCnt <= (mem_req && !mem_ack) ? waitCnt + 1 : 0;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic waitMemReq(input string tag, output logic [31:0] addr);
    addr = 'x;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_req) begin
        addr = mem_addr;
        return;
      end
    end
    checkVal({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic waitReady(input string tag, output logic isIf);
    isIf = 1'bx;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (if_ready || dm_ready) begin
        isIf = if_ready;
        return;
      end
    end
    checkVal({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkVal("rst_state",    32'(dut.state), 32'd0);
    checkVal("rst_memreq",   32'(mem_req), 32'd0);
    checkVal("rst_memwe",    32'(mem_we), 32'd0);
    checkVal("rst_ifready",  32'(if_ready), 32'd0);
    checkVal("rst_dmready",  32'(dm_ready), 32'd0);
    checkVal("rst_ifrdata",  if_rdata, 32'd0);
    checkVal("rst_dmrdata",  dm_rdata, 32'd0);
    checkVal("rst_memaddr",  mem_addr, 32'd0);
    checkVal("rst_memwdata", mem_wdata, 32'd0);
    checkVal("rst_starve",   32'(dut.starveCnt), 32'd0);
    @(posedge clk); #1; rst = 1'b1;

    // Zero-wait fetch
    @(posedge clk); #1; if_req = 1'b1; if_addr = 32'h40;
    @(negedge clk);
    checkVal("fetch_n_memreq", 32'(mem_req), 32'd0);
    checkVal("fetch_n_stall",  32'(stall), 32'd1);
    @(negedge clk);
    checkVal("fetch_n1_memreq", 32'(mem_req), 32'd1);
    checkVal("fetch_n1_addr",   mem_addr, 32'h40);
    checkVal("fetch_n1_we",     32'(mem_we), 32'd0);
    checkVal("fetch_n1_ready",  32'(if_ready), 32'd0);
    @(negedge clk);
    checkVal("fetch_n2_ready",  32'(if_ready), 32'd1);
    checkVal("fetch_n2_rdata",  if_rdata, 32'h8C080004);
    checkVal("fetch_n2_memreq", 32'(mem_req), 32'd0);
    checkVal("fetch_n2_stall",  32'(stall), 32'd0);
    @(posedge clk); #1; if_req = 1'b0;
    @(negedge clk);
    checkVal("fetch_n3_ready",  32'(if_ready), 32'd0);
    checkVal("fetch_n3_memreq", 32'(mem_req), 32'd0);

    // Collision: data first, fetch next, stall held until if_ready
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h80; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h100;
    @(negedge clk);
    checkVal("coll_idle_stall",  32'(stall), 32'd1);
    @(negedge clk);
    checkVal("coll_dm_addr",     mem_addr, 32'h100);
    checkVal("coll_dm_stall",    32'(stall), 32'd1);
    checkVal("coll_dm_starve",   32'(dut.starveCnt), 32'd1);
    @(negedge clk);
    checkVal("coll_dm_ready",    32'(dm_ready), 32'd1);
    checkVal("coll_dm_rdata",    dm_rdata, 32'h0000CAFE);
    checkVal("coll_if_notready", 32'(if_ready), 32'd0);
    checkVal("coll_done_stall",  32'(stall), 32'd1);
    @(posedge clk); #1; dm_req = 1'b0;
    @(negedge clk);
    checkVal("coll_idle2_stall", 32'(stall), 32'd1);
    checkVal("coll_idle2_memreq", 32'(mem_req), 32'd0);
    @(negedge clk);
    checkVal("coll_if_addr",     mem_addr, 32'h80);
    checkVal("coll_if_stall",    32'(stall), 32'd1);
    checkVal("coll_if_starve",   32'(dut.starveCnt), 32'd0);
    @(negedge clk);
    checkVal("coll_if_ready",    32'(if_ready), 32'd1);
    checkVal("coll_if_rdata",    if_rdata, 32'h5A5A0080);
    checkVal("coll_end_stall",   32'(stall), 32'd0);
    @(posedge clk); #1; if_req = 1'b0;

    // Starvation: three data grants, then the fetch
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h200; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h300;
    for (int g = 0; g < 4; g++) begin
      waitMemReq("starve_grant", grantAddr);
      checkVal("starve_addr", grantAddr, (g < 3) ? 32'h300 : 32'h200);
      checkVal("starve_cnt",  32'(dut.starveCnt), (g < 3) ? 32'(g + 1) : 32'd0);
      waitReady("starve_ready", gotIf);
      checkVal("starve_who",  32'(gotIf), (g == 3) ? 32'd1 : 32'd0);
    end
    @(posedge clk); #1; if_req = 1'b0; dm_req = 1'b0;

    // Store with four wait states
    ackDelay = 4;
    @(posedge clk); #1;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h10; dm_wdata = 32'hDEADBEEF;
    @(negedge clk);
    checkVal("st_idle_memreq", 32'(mem_req), 32'd0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checkVal("st_memreq",  32'(mem_req), 32'd1);
      checkVal("st_memwe",   32'(mem_we), 32'd1);
      checkVal("st_addr",    mem_addr, 32'h10);
      checkVal("st_wdata",   mem_wdata, 32'hDEADBEEF);
      checkVal("st_ack",     32'(mem_ack), (c == 4) ? 32'd1 : 32'd0);
      checkVal("st_noready", 32'(dm_ready), 32'd0);
    end
    @(negedge clk);
    checkVal("st_ready",       32'(dm_ready), 32'd1);
    checkVal("st_done_memreq", 32'(mem_req), 32'd0);
    checkVal("st_rdata_hold",  dm_rdata, 32'h5A5A0300);
    @(posedge clk); #1; dm_req = 1'b0; dm_we = 1'b0; ackDelay = 0;
    @(negedge clk);
    checkVal("st_ready_pulse", 32'(dm_ready), 32'd0);

    // Flush during SERVE_IF
    ackDelay = 2;
    @(posedge clk); #1; if_req = 1'b1; if_addr = 32'h44;
    @(negedge clk);
    @(negedge clk);
    checkVal("fl_serve_memreq", 32'(mem_req), 32'd1);
    @(posedge clk); #1; if_flush = 1'b1; if_req = 1'b0;
    @(negedge clk);
    checkVal("fl_flush_memreq", 32'(mem_req), 32'd1);
    checkVal("fl_flush_stall",  32'(stall), 32'd0);
    @(posedge clk); #1; if_flush = 1'b0;
    @(negedge clk);
    checkVal("fl_ack",          32'(mem_ack), 32'd1);
    @(negedge clk);
    checkVal("fl_done_state",   32'(dut.state), 32'd3);
    checkVal("fl_noready",      32'(if_ready), 32'd0);
    checkVal("fl_rdata_hold",   if_rdata, 32'h5A5A0200);
    @(posedge clk); #1; ackDelay = 0;
    @(posedge clk); #1; if_req = 1'b1; if_addr = 32'h48;
    repeat (3) @(negedge clk);
    checkVal("fl_next_ready",   32'(if_ready), 32'd1);
    checkVal("fl_next_rdata",   if_rdata, 32'h5A5A0048);
    @(posedge clk); #1; if_req = 1'b0;

    // Reset in the middle of SERVE_DM
    ackDelay = 3;
    @(posedge clk); #1; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h20;
    @(negedge clk);
    @(negedge clk);
    checkVal("rm_serve_memreq", 32'(mem_req), 32'd1);
    @(posedge clk); #1; rst = 1'b0; dm_req = 1'b0;
    @(posedge clk); #1; rst = 1'b1;
    @(negedge clk);
    checkVal("rm_state",   32'(dut.state), 32'd0);
    checkVal("rm_memreq",  32'(mem_req), 32'd0);
    checkVal("rm_dmrdata", dm_rdata, 32'd0);
    for (int c = 0; c < 4; c++) begin
      checkVal("rm_noready", 32'(dm_ready), 32'd0);
      @(negedge clk);
    end
    ackDelay = 0;
    @(posedge clk); #1; dm_req = 1'b1; dm_addr = 32'h100;
    repeat (3) @(negedge clk);
    checkVal("rm_after_ready", 32'(dm_ready), 32'd1);
    checkVal("rm_after_rdata", dm_rdata, 32'h0000CAFE);
    @(posedge clk); #1; dm_req = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter: ADDR_W, 32, address width (byte address).
REQ-002 SHALL have parameter: DATA_W, 32, data word width.
REQ-003 SHALL have parameter: STARVE_MAX, 3, max consecutive data-port wins while fetch is pending; legal range 1..15.
REQ-004 SHALL have one clock; reset is synchronous and active-low.
REQ-005 SHALL have port: clk  in  1  clock, all logic on rising edge.
REQ-006 SHALL have port: rst  in  1  synchronous active-low reset.
REQ-007 SHALL have ports: if_req in 1, if_addr in ADDR_W, if_flush in 1. This is the instruction-fetch request, address and fetch-cancel.
REQ-008 SHALL have ports: if_rdata out DATA_W, if_ready out 1. This is the fetch data and its 1-cycle completion pulse.
REQ-009 SHALL have ports: dm_req in 1, dm_we in 1, dm_addr in ADDR_W, dm_wdata in DATA_W. This is the data-port request.
REQ-010 SHALL have ports: dm_rdata out DATA_W, dm_ready out 1. This is the load data and its 1-cycle completion pulse.
REQ-011 SHALL have ports: mem_req out 1, mem_we out 1, mem_addr out ADDR_W, mem_wdata out DATA_W. This is the single shared memory port.
REQ-012 SHALL have ports: mem_rdata in DATA_W, mem_ack in 1. mem_ack marks the cycle in which mem_rdata is valid or the write is accepted.
REQ-013 SHALL have port: stall out 1. It is high while any request is pending and not completed this cycle.

Function
REQ-014 SHALL implement states IDLE, SERVE_IF, SERVE_DM, DONE.
REQ-015 In IDLE with any request, SHALL pick a winner, latch its addr/we/wdata into internal registers, and enter SERVE_IF or SERVE_DM on the next edge.
REQ-016 Priority SHALL be: dm over if, except that if wins when if_req=1 and starve_cnt==STARVE_MAX.
REQ-017 starve_cnt (4 bits) SHALL: increment when dm wins while if_req=1; clear when if wins or when dm wins with if_req=0; never exceed STARVE_MAX.
REQ-018 In SERVE_x, SHALL drive mem_req=1 and mem_addr/mem_we/mem_wdata from the latched registers.
REQ-019 mem_we SHALL always be 0 in SERVE_IF.
REQ-020 In SERVE_x, SHALL hold state until mem_ack=1; on that edge capture mem_rdata into the winner's rdata register and enter DONE.
REQ-021 In DONE, SHALL drive mem_req=0 and pulse the winner's ready for exactly 1 cycle, then return to IDLE.
REQ-022 Requests present in DONE SHALL be ignored.
REQ-023 Minimum latency with zero-wait memory: req seen in IDLE at cycle N, mem_req at N+1, ack at N+1, ready at N+2, IDLE at N+3.
REQ-024 Requester SHALL hold req and its inputs stable until ready; the arbiter relies only on the latched copies after grant.
REQ-025 dm_rdata SHALL update only on load completion and hold otherwise. A store completion SHALL pulse dm_ready and leave dm_rdata unchanged.
REQ-026 if_rdata SHALL update only on non-flushed fetch completion and hold otherwise.
REQ-027 if_flush=1 in any cycle of SERVE_IF SHALL set a kill flag. The memory transaction still completes; in DONE, if_ready stays 0 and if_rdata is not updated.
REQ-028 The kill flag SHALL clear on entry to IDLE.
REQ-029 if_flush in IDLE SHALL suppress if_req for arbitration in that cycle.
REQ-030 mem_ack outside SERVE_IF/SERVE_DM SHALL be ignored.
REQ-031 stall SHALL equal (if_req & ~if_ready & ~if_flush) | (dm_req & ~dm_ready), combinational.
REQ-032 The simultaneous if_req and dm_req case in IDLE SHALL be resolved solely by REQ-016; the loser stays pending with stall=1.

Reset
REQ-033 When rst=0 at a rising edge, state SHALL become IDLE.
REQ-034 When rst=0 at a rising edge, SHALL clear starve_cnt and the kill flag.
REQ-035 When rst=0 at a rising edge, SHALL clear mem_req, mem_we, if_ready and dm_ready to 0.
REQ-036 When rst=0 at a rising edge, SHALL clear if_rdata, dm_rdata, mem_addr and mem_wdata to 0.
REQ-037 Reset asserted mid-transaction SHALL abandon the transaction with no ready pulse. mem_req SHALL be 0 in the first cycle after the reset edge.

Verification
REQ-038 Bench SHALL cover: zero-wait fetch. if_req=1, if_addr=0x40, mem_ack same cycle as mem_req, mem_rdata=0x8C080004 -> if_ready pulses at N+2, if_rdata=0x8C080004.
REQ-039 Bench SHALL cover: a collision. if_req and dm_req (load, addr 0x100) both asserted in IDLE -> dm served first; if served next; stall high throughout until if_ready.
REQ-040 Bench SHALL cover: starvation. STARVE_MAX=3, if_req held high, dm_req re-asserted after each dm_ready -> exactly 3 dm grants, then an if grant, then starve_cnt=0.
REQ-041 Bench SHALL cover: a wait-state store. dm_we=1, addr 0x10, wdata 0xDEADBEEF, mem_ack delayed 4 cycles -> mem_req high 5 cycles; mem_we=1 and mem_wdata=0xDEADBEEF held stable; dm_ready 1 pulse; dm_rdata unchanged.
REQ-042 Bench SHALL cover: a flush. if_flush pulsed during SERVE_IF -> mem transaction completes, if_ready stays 0, if_rdata keeps its old value.
REQ-043 Bench SHALL cover: reset mid-SERVE_DM. rst=0 for 1 cycle -> state IDLE, mem_req=0 and no dm_ready pulse.
